// File: rtl/demux_tdm4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_tdm4_pkg : shared FSM state type and channel index constants    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package demux_tdm4_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    // Bit 0 corresponds to channel a.
    function automatic logic [3:0] ch_onehot(input logic [1:0] idx);
        ch_onehot = 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_slot_ctr : TDM frame FSM, slot counter and sync error detector  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module demux_slot_ctr
    import demux_tdm4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tdm_en,
    input  logic       restart,
    input  logic       beat,
    input  logic       sync,
    output logic [1:0] slot,
    output logic       tdm_wr,
    output logic [1:0] tdm_idx,
    output logic       sync_err
);

    state_t     r_state;
    state_t     w_state_nxt;
    state_t     w_state_eff;
    logic [1:0] r_slot;
    logic [1:0] w_slot_nxt;
    logic [1:0] w_slot_eff;
    logic       r_sync_err;
    logic       w_sync_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_slot     <= 2'd0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot     <= w_slot_nxt;
            r_sync_err <= w_sync_err_nxt;
        end
    end

    always_comb begin
        // A mode change restarts framing, but the current beat is still evaluated.
        w_state_eff    = restart ? IDLE : r_state;
        w_slot_eff     = restart ? 2'd0 : r_slot;
        w_state_nxt    = w_state_eff;
        w_slot_nxt     = w_slot_eff;
        w_sync_err_nxt = 1'b0;
        tdm_wr         = 1'b0;
        tdm_idx        = w_slot_eff;

        if (!tdm_en) begin
            w_state_nxt = IDLE;
            w_slot_nxt  = 2'd0;
        end else begin
            case (w_state_eff)
                IDLE: begin
                    w_slot_nxt = 2'd0;
                    if (beat && sync) begin
                        tdm_wr      = 1'b1;
                        tdm_idx     = CH_A;
                        w_slot_nxt  = 2'd1;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (sync) begin
                        w_sync_err_nxt = (w_slot_eff != 2'd0);
                        if (beat) begin
                            tdm_wr     = 1'b1;
                            tdm_idx    = CH_A;
                            w_slot_nxt = 2'd1;
                        end else begin
                            w_slot_nxt = 2'd0;
                        end
                    end else if (beat) begin
                        tdm_wr     = 1'b1;
                        w_slot_nxt = w_slot_eff + 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_slot_nxt  = 2'd0;
                end
            endcase
        end
    end

    assign slot     = r_slot;
    assign sync_err = r_sync_err;

endmodule
`default_nettype wire

// File: rtl/demux_tdm4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_tdm4 : 1-to-4 demux, explicit select or TDM auto-slot steering  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module demux_tdm4
    import demux_tdm4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             mode,
    input  logic             s0,
    input  logic             s1,
    input  logic             sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             a_vld,
    output logic             b_vld,
    output logic             c_vld,
    output logic             d_vld,
    output logic [1:0]       slot,
    output logic             frame_done,
    output logic             sync_err
);

    logic [WIDTH-1:0] r_ch [4];
    logic [3:0]       r_vld;
    logic             r_frame_done;
    logic             r_mode_prev;

    logic             w_restart;
    logic             w_tdm_wr;
    logic [1:0]       w_tdm_idx;
    logic             w_wr;
    logic [1:0]       w_idx;
    logic [3:0]       w_sel;

    assign w_restart = (mode != r_mode_prev);

    demux_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .tdm_en   (mode),
        .restart  (w_restart),
        .beat     (din_valid),
        .sync     (sync),
        .slot     (slot),
        .tdm_wr   (w_tdm_wr),
        .tdm_idx  (w_tdm_idx),
        .sync_err (sync_err)
    );

    assign w_wr  = mode ? w_tdm_wr : din_valid;
    assign w_idx = mode ? w_tdm_idx : {s0, s1};
    assign w_sel = w_wr ? ch_onehot(w_idx) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld        <= 4'b0000;
            r_frame_done <= 1'b0;
            r_mode_prev  <= 1'b0;
        end else begin
            r_vld        <= w_sel;
            r_frame_done <= mode && w_tdm_wr && (w_tdm_idx == CH_D);
            r_mode_prev  <= mode;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ch[i] <= '0;
            end else if (w_sel[i]) begin
                r_ch[i] <= din;
            end
        end
    end

    assign a          = r_ch[CH_A];
    assign b          = r_ch[CH_B];
    assign c          = r_ch[CH_C];
    assign d          = r_ch[CH_D];
    assign a_vld      = r_vld[CH_A];
    assign b_vld      = r_vld[CH_B];
    assign c_vld      = r_vld[CH_C];
    assign d_vld      = r_vld[CH_D];
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
